// File: rtl/rgb_alarm_core.sv
`default_nettype none
// ============================================================================
// Module      : rgb_alarm_core
// Description : RGB LED alarm engine - prescaled 3-channel PWM with an on/off
//               blink sequencer, repeat limit and status readback.
// Revision    : 1.0 - initial release
// ============================================================================
module rgb_alarm_core #(
  parameter int PWM_BITS = 8,
  parameter int PRE_W    = 16,
  parameter int BLINK_W  = 8
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  cfg_enable,
  input  logic                  alarm_set,
  input  logic                  alarm_clr,
  input  logic [3*PWM_BITS-1:0] color_rgb,
  input  logic [PRE_W-1:0]      prescale,
  input  logic [BLINK_W-1:0]    blink_half,
  input  logic [BLINK_W-1:0]    blink_limit,
  output logic                  led_r,
  output logic                  led_g,
  output logic                  led_b,
  output logic                  alarm_active,
  output logic                  alarm_done,
  output logic [BLINK_W-1:0]    blink_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [PWM_BITS-1:0] C_PWM_MAX   = '1;
  localparam logic [PWM_BITS-1:0] C_PWM_ONE   = PWM_BITS'(1);
  localparam logic [PRE_W-1:0]    C_PRE_ONE   = PRE_W'(1);
  localparam logic [BLINK_W-1:0]  C_BLINK_ONE = BLINK_W'(1);

  state_t                  state_q, state_d;
  logic [PRE_W-1:0]        pre_cnt_q, pre_cnt_d;
  logic [PWM_BITS-1:0]     pwm_cnt_q, pwm_cnt_d;
  logic [BLINK_W-1:0]      phase_cnt_q, phase_cnt_d;
  logic [BLINK_W-1:0]      blink_cnt_q, blink_cnt_d;
  logic [3*PWM_BITS-1:0]   duty_q, duty_d;
  logic [2:0]              led_q, led_d;
  logic                    active_q, active_d;
  logic                    done_q, done_d;

  logic                    w_tick;
  logic                    w_per_end;
  logic                    w_phase_end;
  logic                    w_start;
  logic                    w_led_en;
  logic [BLINK_W-1:0]      w_blink_nxt;
  logic [BLINK_W-1:0]      w_blink_sat;

  always_comb begin
    w_tick      = (pre_cnt_q >= prescale);
    w_per_end   = w_tick && (pwm_cnt_q == C_PWM_MAX);
    w_phase_end = w_per_end && (blink_half != '0) &&
                  (phase_cnt_q == blink_half - C_BLINK_ONE);
    w_start     = cfg_enable && alarm_set && !alarm_clr;
    w_blink_nxt = blink_cnt_q + C_BLINK_ONE;
    w_blink_sat = (blink_cnt_q == '1) ? blink_cnt_q : w_blink_nxt;
  end

  always_comb begin
    state_d     = state_q;
    pre_cnt_d   = pre_cnt_q;
    pwm_cnt_d   = pwm_cnt_q;
    phase_cnt_d = phase_cnt_q;
    blink_cnt_d = blink_cnt_q;
    done_d      = done_q;
    // Colour is only adopted at a period boundary so a write never splits a period.
    duty_d      = (state_q == S_IDLE || w_start || w_per_end) ? color_rgb : duty_q;

    if (!cfg_enable) begin
      state_d     = S_IDLE;
      pre_cnt_d   = '0;
      pwm_cnt_d   = '0;
      phase_cnt_d = '0;
      blink_cnt_d = '0;
      done_d      = 1'b0;
    end else if (alarm_clr) begin
      state_d     = S_IDLE;
      pre_cnt_d   = '0;
      pwm_cnt_d   = '0;
      phase_cnt_d = '0;
      done_d      = 1'b0;
    end else if (w_start) begin
      state_d     = S_ON;
      pre_cnt_d   = '0;
      pwm_cnt_d   = '0;
      phase_cnt_d = '0;
      blink_cnt_d = '0;
      done_d      = 1'b0;
    end else begin
      case (state_q)
        S_ON, S_OFF: begin
          pre_cnt_d = w_tick ? '0 : pre_cnt_q + C_PRE_ONE;
          if (w_tick) begin
            pwm_cnt_d = pwm_cnt_q + C_PWM_ONE;
          end
          if (w_phase_end) begin
            phase_cnt_d = '0;
            if (state_q == S_ON) begin
              state_d = S_OFF;
            end else begin
              blink_cnt_d = w_blink_sat;
              if ((blink_limit != '0) && (w_blink_nxt == blink_limit)) begin
                state_d = S_DONE;
                done_d  = 1'b1;
              end else begin
                state_d = S_ON;
              end
            end
          end else if (w_per_end) begin
            phase_cnt_d = phase_cnt_q + C_BLINK_ONE;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = state_q;
      endcase
    end

    active_d = (state_d == S_ON) || (state_d == S_OFF);
    // Leds stay dark on the cycle an alarm (re)starts or leaves ON.
    w_led_en = (state_q == S_ON) && (state_d == S_ON) && !w_start;
    for (int i = 0; i < 3; i++) begin
      led_d[i] = w_led_en && (pwm_cnt_q < duty_q[i*PWM_BITS +: PWM_BITS]);
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= S_IDLE;
      pre_cnt_q   <= '0;
      pwm_cnt_q   <= '0;
      phase_cnt_q <= '0;
      blink_cnt_q <= '0;
      duty_q      <= '0;
      led_q       <= '0;
      active_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pre_cnt_q   <= pre_cnt_d;
      pwm_cnt_q   <= pwm_cnt_d;
      phase_cnt_q <= phase_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      duty_q      <= duty_d;
      led_q       <= led_d;
      active_q    <= active_d;
      done_q      <= done_d;
    end
  end

  assign led_r        = led_q[2];
  assign led_g        = led_q[1];
  assign led_b        = led_q[0];
  assign alarm_active = active_q;
  assign alarm_done   = done_q;
  assign blink_cnt    = blink_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_rgb_alarm_core.sv
`default_nettype none
// Bench for rgb_alarm_core: per-cycle scoreboard fed by a model that derives
// every output from the elapsed time since the alarm started.
module tb_rgb_alarm_core;

  logic        ACLK        = 1'b0;
  logic        ARESETN     = 1'b0;
  logic        cfg_enable  = 1'b0;
  logic        alarm_set   = 1'b0;
  logic        alarm_clr   = 1'b0;
  logic [23:0] color_rgb   = '0;
  logic [15:0] prescale    = '0;
  logic [7:0]  blink_half  = '0;
  logic [7:0]  blink_limit = '0;
  logic        led_r, led_g, led_b, alarm_active, alarm_done;
  logic [7:0]  blink_cnt;

  rgb_alarm_core #(.PWM_BITS(8), .PRE_W(16), .BLINK_W(8)) dut (
    .ACLK        (ACLK),
    .ARESETN     (ARESETN),
    .cfg_enable  (cfg_enable),
    .alarm_set   (alarm_set),
    .alarm_clr   (alarm_clr),
    .color_rgb   (color_rgb),
    .prescale    (prescale),
    .blink_half  (blink_half),
    .blink_limit (blink_limit),
    .led_r       (led_r),
    .led_g       (led_g),
    .led_b       (led_b),
    .alarm_active(alarm_active),
    .alarm_done  (alarm_done),
    .blink_cnt   (blink_cnt)
  );

  always #5 ACLK = ~ACLK;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [12:0] exp_q[$];

  bit          m_run   = 1'b0;
  longint      m_j     = 0;
  longint      m_p     = 1;
  longint      m_pp    = 256;
  longint      m_h     = 0;
  longint      m_l     = 0;
  logic [23:0] m_duty  = '0;
  logic [7:0]  m_blink = '0;
  bit          m_done  = 1'b0;

  function automatic logic [12:0] outs();
    return {led_r, led_g, led_b, alarm_active, alarm_done, blink_cnt};
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s t=%0t actual=0x%0h required=0x%0h", name, $time, act, req);
    end
  endtask

  // Blink phase index of cycle j (only meaningful when m_h != 0).
  function automatic longint f_phase(longint j);
    return (j / m_pp) / m_h;
  endfunction

  function automatic bit f_is_done(longint j);
    if (m_h == 0 || m_l == 0) return 1'b0;
    return f_phase(j) >= 2 * m_l;
  endfunction

  function automatic bit f_on(longint j);
    if (f_is_done(j)) return 1'b0;
    if (m_h == 0) return 1'b1;
    return (f_phase(j) % 2) == 0;
  endfunction

  function automatic logic [7:0] f_blink(longint j);
    longint c;
    if (m_h == 0) return 8'd0;
    if (f_is_done(j)) return 8'(m_l);
    c = f_phase(j) / 2;
    return (c > 255) ? 8'd255 : 8'(c);
  endfunction

  // Advance the model across one clock edge and queue the outputs expected after it.
  task automatic model_edge();
    logic [2:0] led;
    longint     pwm;
    led = 3'b000;
    if (!cfg_enable) begin
      m_run = 1'b0; m_blink = '0; m_done = 1'b0;
    end else if (alarm_clr) begin
      if (m_run) m_blink = f_blink(m_j);
      m_run = 1'b0; m_done = 1'b0;
    end else if (alarm_set) begin
      m_run  = 1'b1;
      m_j    = 0;
      m_p    = longint'(prescale) + 1;
      m_pp   = m_p * 256;
      m_h    = longint'(blink_half);
      m_l    = longint'(blink_limit);
      m_duty = color_rgb;
    end else if (m_run) begin
      if (f_on(m_j)) begin
        pwm = (m_j / m_p) % 256;
        for (int c = 0; c < 3; c++) led[c] = (pwm < longint'(m_duty[c*8 +: 8]));
      end
      m_j++;
      if (m_j % m_pp == 0) m_duty = color_rgb;
      if (m_h != 0 && m_l != 0 && m_j > 2 * m_l * m_h * m_pp) begin
        m_run = 1'b0; m_blink = 8'(m_l); m_done = 1'b1;
      end
    end
    if (m_run) exp_q.push_back({led, !f_is_done(m_j), f_is_done(m_j), f_blink(m_j)});
    else       exp_q.push_back({3'b000, 1'b0, m_done, m_blink});
  endtask

  task automatic tick(input bit set = 1'b0, input bit clr = 1'b0);
    @(negedge ACLK);
    alarm_set = set;
    alarm_clr = clr;
    model_edge();
    @(posedge ACLK);
    #2;
    alarm_set = 1'b0;
    alarm_clr = 1'b0;
  endtask

  initial begin
    logic [12:0] e;
    forever begin
      @(posedge ACLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("outputs", longint'(outs()), longint'(e));
      end
    end
  end

  initial begin
    int cr, cg, cb, mixed, len, r;

    repeat (2) @(posedge ACLK);
    #2;
    check("reset_state", longint'(outs()), 0);
    ARESETN    = 1'b1;
    cfg_enable = 1'b1;
    @(posedge ACLK);
    #2;

    // Steady colour
    color_rgb = 24'h8000FF; prescale = '0; blink_half = '0; blink_limit = '0;
    tick(1'b1);
    check("steady_active", longint'(alarm_active), 1);
    repeat (10) tick();
    cr = 0; cg = 0; cb = 0;
    for (int k = 0; k < 256; k++) begin
      tick();
      cr += int'(led_r); cg += int'(led_g); cb += int'(led_b);
    end
    check("steady_r_count", cr, 128);
    check("steady_g_count", cg, 0);
    check("steady_b_count", cb, 255);
    check("steady_blink", longint'(blink_cnt), 0);
    tick(1'b0, 1'b1);
    tick();

    // Limited blink
    color_rgb = 24'hFFFFFF; blink_half = 8'd2; blink_limit = 8'd3;
    tick(1'b1);
    repeat (3072) tick();
    check("limit_done", longint'(outs()), 259);
    repeat (3) tick();
    check("limit_idle_sticky", longint'(outs()), 259);

    // Colour update mid-period
    color_rgb = 24'hFF0000; blink_half = '0; blink_limit = '0;
    tick(1'b1);
    repeat (100) tick();
    color_rgb = 24'h00FF00;
    mixed = 0;
    for (int k = 0; k < 400; k++) begin
      tick();
      if (led_r && led_g) mixed++;
    end
    check("colour_no_mix", mixed, 0);
    tick(1'b0, 1'b1);

    // Same-cycle strobes
    tick(1'b1, 1'b1);
    check("strobes_idle", longint'(alarm_active), 0);
    blink_half = 8'd1;
    tick(1'b1);
    repeat (600) tick();
    tick(1'b1, 1'b1);
    check("strobes_on_blink", longint'(blink_cnt), 1);
    check("strobes_on_active", longint'(alarm_active), 0);

    // Restart during OFF, then disable mid-blink
    tick(1'b1);
    repeat (1300) tick();
    check("pre_restart_blink", longint'(blink_cnt), 2);
    tick(1'b1);
    check("restart_blink", longint'(blink_cnt), 0);
    check("restart_active", longint'(alarm_active), 1);
    repeat (700) tick();
    cfg_enable = 1'b0;
    tick();
    check("disable_all_zero", longint'(outs()), 0);
    cfg_enable = 1'b1;
    tick(1'b1);
    check("disable_set_ignored_prev", longint'(alarm_active), 1);

    // Asynchronous reset mid-ON
    color_rgb = 24'hFFFFFF; blink_half = '0;
    tick(1'b1);
    repeat (20) tick();
    check("pre_reset_led", longint'(led_r), 1);
    #1;
    ARESETN = 1'b0;
    #1;
    check("async_reset", longint'(outs()), 0);
    m_run = 1'b0; m_blink = '0; m_done = 1'b0;
    @(negedge ACLK);
    @(negedge ACLK);
    #1;
    ARESETN = 1'b1;
    @(posedge ACLK);
    #2;
    repeat (20) tick();
    check("post_reset_idle", longint'(alarm_active), 0);

    // Randomised segments
    for (int s = 0; s < 15; s++) begin
      prescale    = 16'($urandom_range(0, 1));
      blink_half  = 8'($urandom_range(0, 2));
      blink_limit = 8'($urandom_range(0, 2));
      color_rgb   = 24'($urandom);
      tick(1'b1);
      len = $urandom_range(300, 3000);
      for (int k = 0; k < len; k++) begin
        r = $urandom_range(0, 2999);
        if (r >= 4 && r < 14) color_rgb = 24'($urandom);
        if (r == 14) cfg_enable = 1'b0;
        tick(r < 2, (r >= 2) && (r < 4));
        cfg_enable = 1'b1;
      end
    end

    @(posedge ACLK);
    #2;
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rgb_alarm_core.md
Name: rgb_alarm_core

Overview:
Alarm engine downstream of the rgb_alarm AXI4-Lite register slave; consumes that slave's configuration/strobe outputs and drives the RGB LED pins.
- Generates per-channel 8-bit PWM colour from a prescaled tick.
- Sequences an on/off blink pattern with an optional repeat limit.
- Returns status (active, done, blink count) to the register bank for readback.

Parameters:
- PWM_BITS, 8: PWM counter and duty width per channel.
- PRE_W, 16: prescaler width.
- BLINK_W, 8: width of the blink half-period, limit and count fields.

Ports:
- ACLK  in  1  system clock.
- ARESETN  in  1  reset; asynchronous, active-low.
- cfg_enable  in  1  core enable; 0 forces IDLE and clears all counters.
- alarm_set  in  1  single-cycle start/restart pulse.
- alarm_clr  in  1  single-cycle stop pulse; also clears alarm_done.
- color_rgb  in  3*PWM_BITS  duty values {R,G,B}, R in the MSBs.
- prescale  in  PRE_W  PWM tick every prescale+1 clocks.
- blink_half  in  BLINK_W  PWM periods per ON or OFF phase; 0 = steady on.
- blink_limit  in  BLINK_W  on/off cycles before auto-stop; 0 = unlimited.
- led_r, led_g, led_b  out  1 each  registered PWM outputs.
- alarm_active  out  1  high in ON or OFF state.
- alarm_done  out  1  sticky; set when the limit is reached.
- blink_cnt  out  BLINK_W  completed on/off cycles.

Behaviour:
- Reset (ARESETN=0, asynchronous): state=IDLE; pre_cnt, pwm_cnt, phase_cnt, blink_cnt, duty shadow = 0; all outputs 0.
- Prescaler:
  - tick = (pre_cnt >= prescale); on tick pre_cnt <= 0, else pre_cnt+1.
  - Using >= means lowering prescale mid-count fires a tick on the next cycle.
- PWM counter:
  - pwm_cnt increments on tick and wraps 2^PWM_BITS-1 -> 0.
  - per_end = tick && pwm_cnt==max.
  - With prescale=0 one period is 256 clocks.
- Duty shadow:
  - Loaded from color_rgb in IDLE every cycle, and otherwise only on per_end.
  - A mid-period colour write therefore takes effect at the next period start, with no glitch.
- States:
  - IDLE -> ON on alarm_set (with cfg_enable=1). pre_cnt, pwm_cnt, phase_cnt and blink_cnt zero; alarm_done cleared.
  - ON -> OFF on per_end when blink_half!=0 and phase_cnt==blink_half-1; phase_cnt <= 0. Otherwise phase_cnt increments on per_end.
  - OFF -> ON on the same phase condition; blink_cnt increments, saturating at max.
  - OFF -> DONE instead of ON when blink_limit!=0 and blink_cnt+1==blink_limit; blink_cnt still increments and alarm_done <= 1.
  - DONE -> IDLE the next cycle; alarm_done stays high.
  - blink_half=0: remain in ON indefinitely; blink_cnt stays 0; blink_limit is ignored.
- alarm_set while ON or OFF: restart into ON with all counters zeroed.
- alarm_clr in any state: -> IDLE, alarm_done <= 0, blink_cnt held for readback.
- alarm_set and alarm_clr in the same cycle: alarm_clr wins.
- cfg_enable=0: synchronous forced IDLE; all counters, blink_cnt and alarm_done cleared; alarm_set ignored.
- Outputs:
  - led_x registered: led_x(next) = (state==ON) && (pwm_cnt < duty_x).
  - duty=0 gives constant off; duty=255 gives on for 255 of 256 ticks.
  - The first led high appears one clock after alarm_active rises.
  - OFF, IDLE and DONE drive all leds 0.
- alarm_active = registered (state==ON || state==OFF); it rises on the edge that samples alarm_set.
- Reset asserted mid-alarm: all outputs go 0 immediately (asynchronous); after release the core is in IDLE and needs a new alarm_set.

Test Plan:
- Steady colour. prescale=0, blink_half=0, color_rgb=0x8000FF, pulse alarm_set. Measured over one 256-clock period:
  - led_r high exactly 128 clocks, led_g always 0, led_b high 255 clocks.
  - alarm_active=1, blink_cnt=0.
- Limited blink. prescale=0, blink_half=2, blink_limit=3:
  - ON 512 clocks, OFF 512 clocks, repeated 3 times.
  - DONE after 3072 clocks; alarm_done=1, blink_cnt=3, alarm_active=0, leds 0.
- Colour update timing. color_rgb changed from 0xFF0000 to 0x00FF00 at pwm_cnt=100:
  - led_r stays high until the period ends; led_g starts at the next period; no mixed-colour cycle.
- Same-cycle strobes. In IDLE assert alarm_set and alarm_clr together -> stays IDLE, alarm_active=0. Repeat during ON -> IDLE, blink_cnt held.
- Restart and disable:
  - alarm_set during OFF with blink_cnt=2 -> ON, blink_cnt=0.
  - cfg_enable=0 mid-blink -> IDLE, blink_cnt=0, alarm_done=0.
- Asynchronous reset. Drop ARESETN at a non-clock-aligned time during ON:
  - leds and alarm_active go 0 without waiting for a clock edge.
  - After release, state IDLE until alarm_set.
